// File: rtl/tof_sequencer.sv
// Ultrasound time-of-flight shot controller: aligns a TX burst to the sliding-DFT
// window, blanks, then times the first echo-magnitude threshold crossing.
module tof_sequencer #(
    parameter int HALF_PERIOD  = 5,
    parameter int BURST_CYCLES = 8,
    parameter int BLANK_CLKS   = 800,
    parameter int MAX_CLKS     = 65535,
    parameter int WINDOW       = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [64:0] threshold,
    input  logic [8:0]  offset,
    input  logic [63:0] cos_sum,
    input  logic [63:0] sin_sum,
    output logic        tx_en,
    output logic        tx_phase,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] tof
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        BURST  = 3'd2,
        BLANK  = 3'd3,
        LISTEN = 3'd4
    } state_t;

    // Phase boundaries expressed as shot-timer values (timer is 0 in the first BURST cycle).
    localparam logic [31:0] BURST_LAST  = 32'(2 * HALF_PERIOD * BURST_CYCLES - 1);
    localparam logic [31:0] BLANK_LAST  = 32'(2 * HALF_PERIOD * BURST_CYCLES + BLANK_CLKS - 1);
    localparam logic [31:0] MAX_TIME    = 32'(MAX_CLKS);
    localparam logic [8:0]  OFFSET_LAST = 9'(WINDOW - 1);
    localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

    // Two's-complement magnitude; the most negative input maps to 2^63 without overflow.
    function automatic logic [63:0] abs64(input logic [63:0] v);
        if (v[63]) begin
            abs64 = ~v + 64'd1;
        end else begin
            abs64 = v;
        end
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] timer_r, timer_nxt_s, timer_inc_s;
    logic [15:0] half_cnt_r, half_nxt_s;
    logic        tx_phase_r, phase_nxt_s;
    logic        tx_en_r, busy_r, done_r, done_nxt_s;
    logic        timeout_r, timeout_nxt_s;
    logic [31:0] tof_r, tof_nxt_s;
    logic [64:0] thr_r, thr_nxt_s;
    logic [64:0] mag_r;
    logic        hit_r, lst_d1_r, lst_d2_r, hit_count_s;
    logic [31:0] tmr_d1_r, tmr_d2_r;

    // Magnitude/compare pipeline with timer and LISTEN flag delayed alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r    <= 65'd0;
            hit_r    <= 1'b0;
            lst_d1_r <= 1'b0;
            lst_d2_r <= 1'b0;
            tmr_d1_r <= 32'd0;
            tmr_d2_r <= 32'd0;
        end else begin
            mag_r    <= {1'b0, abs64(cos_sum)} + {1'b0, abs64(sin_sum)};
            hit_r    <= (mag_r >= thr_r);
            lst_d1_r <= (state_r == LISTEN);
            lst_d2_r <= lst_d1_r;
            tmr_d1_r <= timer_r;
            tmr_d2_r <= tmr_d1_r;
        end
    end

    // Next-state, timer, TX waveform and result logic.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        half_nxt_s    = half_cnt_r;
        phase_nxt_s   = 1'b0;
        done_nxt_s    = 1'b0;
        timeout_nxt_s = timeout_r;
        tof_nxt_s     = tof_r;
        thr_nxt_s     = thr_r;
        hit_count_s   = hit_r & lst_d2_r & (state_r == LISTEN);
        timer_inc_s   = (timer_r == 32'hFFFF_FFFF) ? timer_r : timer_r + 32'd1;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s   = ALIGN;
                    thr_nxt_s     = threshold;
                    timeout_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ALIGN: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (offset == OFFSET_LAST) begin
                    state_nxt_s = BURST;
                    timer_nxt_s = 32'd0;
                    half_nxt_s  = 16'd0;
                    phase_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ALIGN;
                end
            end
            BURST: begin
                timer_nxt_s = timer_inc_s;
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (timer_r == BURST_LAST) begin
                    state_nxt_s = BLANK;
                end else begin
                    state_nxt_s = BURST;
                    half_nxt_s  = (half_cnt_r == HALF_LAST) ? 16'd0 : half_cnt_r + 16'd1;
                    phase_nxt_s = (half_cnt_r == HALF_LAST) ? ~tx_phase_r : tx_phase_r;
                end
            end
            BLANK: begin
                timer_nxt_s = timer_inc_s;
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (timer_r == BLANK_LAST) begin
                    state_nxt_s = LISTEN;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            LISTEN: begin
                timer_nxt_s = timer_inc_s;
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (hit_count_s) begin
                    state_nxt_s   = IDLE;
                    done_nxt_s    = 1'b1;
                    tof_nxt_s     = tmr_d2_r;
                    timeout_nxt_s = 1'b0;
                end else if (timer_r >= MAX_TIME) begin
                    state_nxt_s   = IDLE;
                    done_nxt_s    = 1'b1;
                    tof_nxt_s     = MAX_TIME;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = LISTEN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            timer_r    <= 32'd0;
            half_cnt_r <= 16'd0;
            tx_phase_r <= 1'b0;
            tx_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            tof_r      <= 32'd0;
            thr_r      <= 65'd0;
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            half_cnt_r <= half_nxt_s;
            tx_phase_r <= phase_nxt_s;
            tx_en_r    <= (state_nxt_s == BURST);
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= done_nxt_s;
            timeout_r  <= timeout_nxt_s;
            tof_r      <= tof_nxt_s;
            thr_r      <= thr_nxt_s;
        end
    end

    assign tx_en    = tx_en_r;
    assign tx_phase = tx_phase_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign timeout  = timeout_r;
    assign tof      = tof_r;

endmodule

// File: tb/tb_tof_sequencer.sv
// Scoreboard bench for tof_sequencer: stimulus queues expected burst phases and
// shot results; a negedge monitor pops and compares when the DUT presents them.
module tb_tof_sequencer;

    localparam int HP   = 5;
    localparam int BC   = 2;
    localparam int BLK  = 20;
    localparam int MAXC = 100;
    localparam int WIN  = 400;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [64:0] threshold;
    logic [8:0]  offset;
    logic [63:0] cos_sum, sin_sum;
    logic        tx_en, tx_phase, busy, done, timeout;
    logic [31:0] tof;

    tof_sequencer #(
        .HALF_PERIOD(HP), .BURST_CYCLES(BC), .BLANK_CLKS(BLK), .MAX_CLKS(MAXC), .WINDOW(WIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .threshold(threshold),
        .offset(offset), .cos_sum(cos_sum), .sin_sum(sin_sum), .tx_en(tx_en),
        .tx_phase(tx_phase), .busy(busy), .done(done), .timeout(timeout), .tof(tof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] tof;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    bit   phase_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   tcur    = 0;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Free-running DFT offset counter, changing just after each rising edge.
    initial begin
        offset = 9'd0;
        forever begin
            @(posedge clk);
            #1;
            offset = (offset == 9'(WIN - 1)) ? 9'd0 : offset + 9'd1;
        end
    end

    // Monitor: burst waveform and shot results against the queued expectations.
    initial begin
        bit   prev_tx;
        bit   p;
        exp_t e;
        prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en) begin
                if (!prev_tx) check("tx_rise_offset", offset, 0);
                check("tx_en_expected", phase_q.size() != 0, 1);
                if (phase_q.size() != 0) begin
                    p = phase_q.pop_front();
                    check("tx_phase", tx_phase, p);
                end
            end else if (prev_tx) begin
                check("tx_phase_after_burst", tx_phase, 0);
            end
            prev_tx = tx_en;
            if (done) begin
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tof", tof, e.tof);
                    check("timeout", timeout, e.timeout);
                    check("busy_at_done", busy, 0);
                    check("tx_en_at_done", tx_en, 0);
                end
            end
        end
    end

    task automatic launch(input logic [64:0] thr);
        threshold = thr;
        start     = 1'b1;
        for (int i = 0; i < 2 * HP * BC; i++) phase_q.push_back(((i / HP) % 2) == 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_tx();
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (tx_en) ok = 1'b1;
        end
        check("burst_started", ok, 1);
        tcur = 0;
    endtask

    task automatic go_to(input int t);
        repeat (t - tcur) @(negedge clk);
        tcur = t;
    endtask

    task automatic pulse_sums(input logic [63:0] c, input logic [63:0] s);
        cos_sum = c;
        sin_sum = s;
        @(negedge clk);
        tcur++;
        cos_sum = 64'd0;
        sin_sum = 64'd0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check("shot_ended", ok, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        threshold = 65'd0; cos_sum = 64'd0; sin_sum = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_phase", tx_phase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_tof", tof, 0);
        rst = 1'b0;

        // Alignment from offset 100, detection at timer 57, ignored start in BLANK.
        for (int i = 0; i < 500 && offset != 9'd100; i++) @(negedge clk);
        check("offset_at_start", offset, 100);
        exp_q.push_back('{tof: 32'd57, timeout: 1'b0});
        launch(65'd1000);
        wait_tx();
        go_to(25);
        start = 1'b1;
        @(negedge clk);
        tcur++;
        start = 1'b0;
        go_to(57);
        pulse_sums(64'd600, -64'sd500);
        wait_idle();

        // Hit in BLANK and a 999 total in LISTEN are ignored; the shot times out.
        exp_q.push_back('{tof: 32'd100, timeout: 1'b1});
        launch(65'd1000);
        wait_tx();
        go_to(30);
        pulse_sums(64'd600, -64'sd500);
        go_to(50);
        pulse_sums(64'd500, -64'sd499);
        wait_idle();

        // Acceptance clears timeout; |-2^63| exactly meets a 2^63 threshold.
        exp_q.push_back('{tof: 32'd45, timeout: 1'b0});
        launch(65'h0_8000_0000_0000_0000);
        check("busy_after_start", busy, 1);
        check("timeout_cleared", timeout, 0);
        wait_tx();
        go_to(45);
        pulse_sums(64'h8000_0000_0000_0000, 64'd0);
        wait_idle();

        // Last BLANK cycle does not count, first LISTEN cycle does.
        exp_q.push_back('{tof: 32'd40, timeout: 1'b0});
        launch(65'd1000);
        wait_tx();
        go_to(39);
        pulse_sums(64'd600, -64'sd500);
        pulse_sums(-64'sd700, 64'd400);
        wait_idle();

        // Hit decided in the timeout cycle wins.
        exp_q.push_back('{tof: 32'd98, timeout: 1'b0});
        launch(65'd1000);
        wait_tx();
        go_to(98);
        pulse_sums(64'd600, -64'sd500);
        wait_idle();

        // Abort in the third BURST cycle.
        launch(65'd1000);
        wait_tx();
        go_to(2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_tx_en", tx_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_tof", tof, 98);
        check("abort_timeout", timeout, 0);
        phase_q.delete();
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_tof", tof, 98);

        // Reset mid-LISTEN.
        launch(65'd1000);
        wait_tx();
        go_to(45);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_tx_phase", tx_phase, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_tof", tof, 0);

        repeat (150) @(negedge clk);
        check("results_outstanding", exp_q.size(), 0);
        check("phases_outstanding", phase_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop if the run ever wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tof_sequencer.md
Name: tof_sequencer

Overview:
- Measurement controller for one ultrasound time-of-flight shot.
- Waits for the sliding-DFT offset counter to wrap, then drives a phase-aligned TX burst to the transducer driver.
- Blanks for a programmable time, then watches the DFT cos/sin sums for an echo-magnitude threshold crossing.
- Reports the crossing time in clocks, or a timeout if no crossing occurs.

Parameters:
- HALF_PERIOD, 5, clocks per TX half-cycle; the carrier period is 2*HALF_PERIOD.
- BURST_CYCLES, 8, number of full TX carrier periods per burst.
- BLANK_CLKS, 800, clocks after burst end during which no detection occurs; default is two DFT windows.
- MAX_CLKS, 65535, timeout limit on the shot timer.
- WINDOW, 400, DFT window length; offset wraps at WINDOW-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle shot request
- abort  in  1  cancel the current shot
- threshold  in  65  unsigned magnitude threshold, sampled when start is accepted
- offset  in  9  DFT offset counter
- cos_sum  in  64  signed DFT cosine sum
- sin_sum  in  64  signed DFT sine sum
- tx_en  out  1  transducer driver enable
- tx_phase  out  1  square-wave drive level
- busy  out  1  shot in progress
- done  out  1  one-cycle completion pulse
- timeout  out  1  last shot ended without a detection
- tof  out  32  detection time in clocks

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset mid-shot: next cycle is IDLE with tx_en=0 and no done pulse.
- States: IDLE, ALIGN, BURST, BLANK, LISTEN.
- IDLE:
  - start=1 latches threshold, clears timeout, and moves to ALIGN; busy=1 from the next cycle.
  - tof holds its previous value until a new result is written.
- ALIGN: when offset==WINDOW-1, go to BURST. The first BURST cycle therefore coincides with offset==0.
- Shot timer:
  - 32 bits; value 0 in the first BURST cycle; +1 every cycle in BURST, BLANK and LISTEN.
  - Saturates at 2^32-1 and is not cleared in ALIGN.
- BURST:
  - tx_en=1 for exactly 2*HALF_PERIOD*BURST_CYCLES cycles.
  - tx_phase=1 for the first HALF_PERIOD cycles, then toggles every HALF_PERIOD cycles.
  - Then go to BLANK with tx_en=0 and tx_phase=0.
- BLANK: lasts exactly BLANK_CLKS cycles, then LISTEN. No detection occurs in BLANK.
- Magnitude pipeline, running every cycle:
  - Stage 1 registers mag = |cos_sum| + |sin_sum| as 65-bit unsigned; |-2^63| = 2^63 with no overflow.
  - Stage 2 registers hit = (mag >= threshold).
  - The timer value is delayed 2 stages alongside, so the reported tof is the timer value of the cycle in which the crossing sums were on the ports.
- LISTEN:
  - Only hits whose sums were sampled in a LISTEN cycle count (a delayed LISTEN flag travels with the pipeline).
  - On the first hit: tof = delayed timer, done=1 for one cycle, timeout=0, return to IDLE.
- Timeout: if the timer reaches MAX_CLKS in LISTEN with no counted hit:
  - tof = MAX_CLKS, timeout=1, done=1, return to IDLE.
  - If a hit and the timeout occur in the same cycle, the hit wins.
- Hits still in flight when the shot leaves LISTEN are discarded.
- busy is high in ALIGN, BURST, BLANK and LISTEN, and low in the cycle done pulses.
- start while busy is ignored. A start in the same cycle as done's IDLE return is accepted on the next IDLE cycle only if re-asserted.
- abort while busy: next cycle is IDLE with tx_en=0; no done pulse; tof and timeout are unchanged. abort in IDLE has no effect.
- rst has priority over abort, and abort has priority over start, hit and timeout.

Test Plan:
- Alignment: HALF_PERIOD=5, BURST_CYCLES=2; start at offset=100 → tx_en rises in the cycle offset==0 and stays high for 20 cycles; tx_phase reads 1×5, 0×5, 1×5, 0×5.
- Detection: BLANK_CLKS=20, threshold=1000; drive cos_sum=600, sin_sum=-500 on the timer=57 cycle (LISTEN starts at timer=40) → done pulse, tof=57, timeout=0.
- Blanking and ignore rules: the same sums at timer=30 (BLANK) → no done. Sums of 999 total at any time → no hit. cos_sum=-2^63, sin_sum=0 with threshold=2^63 → hit.
- Timeout: MAX_CLKS=100, sums held at 0 → done at timer=100, tof=100, timeout=1, busy=0.
- Abort and reset: abort at the 3rd BURST cycle → next cycle tx_en=0, busy=0, no done, tof keeps its prior value. rst mid-LISTEN gives the same result with all outputs 0.
- Re-trigger: start pulsed while busy → ignored, exactly one done for the shot. A second start after done → new shot, and timeout clears on acceptance.
